wingbutled_ctrl_v: RTL and testbench
====================================

WINGBUTLED_CTRL_V -- requirements
Module: wingbutled_ctrl_v

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 32000, giving the consecutive stable synchronized samples needed to accept a button level change (1 ms at 32 MHz); legal range 2..2^20-1.
REQ-002 SHALL provide parameter BLINK_CYCLES, default 8000000, giving the clock cycles per blink half-period; legal range 2..2^24-1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port buttons, input, 4 bits: raw asynchronous wing button levels, 1 = pressed.
REQ-006 SHALL have port leds, output, 4 bits: wing LED drive, 1 = lit.
REQ-007 SHALL have port btn_level, output, 4 bits: debounced button levels.
REQ-008 SHALL have port btn_press, output, 4 bits: one-cycle pulse per debounced press.
REQ-009 SHALL have port led_mode, output, 8 bits: 2-bit mode per channel, bits [2i+1:2i] for channel i.

Function
REQ-010 SHALL pass each buttons bit through a two-flop synchronizer before any other use.
REQ-011 SHALL keep one debounce counter per channel, cleared on any cycle where the synchronized sample equals btn_level[i].
REQ-012 SHALL increment the channel counter on each cycle where the synchronized sample differs from btn_level[i].
REQ-013 SHALL, on the cycle the counter would reach DEBOUNCE_CYCLES, load btn_level[i] with the sample and clear the counter.
REQ-014 SHALL therefore reject glitches shorter than DEBOUNCE_CYCLES cycles, with no change to btn_level or btn_press.
REQ-015 SHALL give a latency of 2 + DEBOUNCE_CYCLES cycles from a clean raw edge to the btn_level update.
REQ-016 SHALL assert btn_press[i] for exactly one cycle, registered, in the same cycle btn_level[i] goes 0->1; no pulse on release.
REQ-017 SHALL process all four channels independently; simultaneous presses SHALL produce simultaneous pulses.
REQ-018 SHALL hold a per-channel mode FSM with states OFF=2'b00, ON=2'b01, BLINK=2'b10; 2'b11 is illegal.
REQ-019 SHALL advance the channel FSM on the cycle after btn_press[i] as OFF->ON->BLINK->OFF; no press SHALL mean no change.
REQ-020 SHALL force an FSM found in 2'b11 to OFF on the next cycle.
REQ-021 SHALL keep one shared free-running prescaler 0..BLINK_CYCLES-1 that wraps to 0 and toggles blink_phase on each wrap.
REQ-022 SHALL keep all BLINK channels in phase.
REQ-023 SHALL register leds[i] from the mode: 0 for OFF, 1 for ON, blink_phase for BLINK, one cycle after the mode or phase change.
REQ-024 SHALL reflect the current FSM states on led_mode combinationally from the state registers.
REQ-025 SHALL use a prescaler width of ceil(log2(BLINK_CYCLES)) and a debounce counter width of ceil(log2(DEBOUNCE_CYCLES+1)); counters SHALL never exceed their terminal value.

Reset
REQ-026 SHALL, while rst_n=0 at a clk edge, clear synchronizers, debounce counters, btn_level, btn_press, all FSMs (OFF), the prescaler and blink_phase to 0.
REQ-027 SHALL output leds=0, btn_level=0, btn_press=0 and led_mode=0 in the first cycle after release.
REQ-028 SHALL discard a press in progress when reset is asserted mid-debounce; a button still held after release SHALL be re-debounced from zero and produce a press.
REQ-029 SHALL treat rst_n only as a synchronous input; its assertion SHALL take effect at the next clk edge only.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=3)
REQ-030 SHALL cover a clean edge: buttons=4'b0001 from cycle 0 -> btn_level[0]=1 and btn_press=4'b0001 for one cycle at cycle 6; led_mode=8'h01 and leds[0]=1 follow.
REQ-031 SHALL cover a glitch: buttons[2] high for 3 cycles then low -> btn_level, btn_press and led_mode stay 0.
REQ-032 SHALL cover mode cycling: three debounced presses on channel 1 -> led_mode[3:2] goes 01, 10, 00; in BLINK, leds[1] toggles every 3 cycles.
REQ-033 SHALL cover simultaneous presses: buttons=4'b1111 -> btn_press=4'b1111 in one cycle, led_mode=8'h55, leds=4'b1111.
REQ-034 SHALL cover reset mid-debounce: rst_n=0 for one cycle 2 cycles into the channel-3 debounce while the button stays held -> all outputs 0, then press accepted 6 cycles after release.
REQ-035 SHALL cover release: press then release channel 0 -> btn_level[0] falls 6 cycles after the raw fall, with no btn_press pulse and no mode change.

Source files
------------

// File: rtl/wingbutled_ctrl_v.sv
// Four-channel wing button/LED controller: synchronize and debounce each button,
// step a per-channel OFF/ON/BLINK mode on every press, and drive the LEDs from the mode.
module wingbutled_ctrl_v #(
    parameter int unsigned DEBOUNCE_CYCLES = 32000,
    parameter int unsigned BLINK_CYCLES    = 8000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] buttons,
    output logic [3:0] leds,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [7:0] led_mode
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(BLINK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        ON    = 2'b01,
        BLINK = 2'b10
    } mode_t;

    logic [3:0]    sync1, sync2;
    logic [DW-1:0] cnt [4];
    logic [PW-1:0] pre;
    logic          blink_phase;
    mode_t         mode_q [4];
    mode_t         mode_d [4];
    logic [3:0]    leds_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    // Level is accepted on the cycle the counter would reach DEBOUNCE_CYCLES,
    // so the counter itself never holds the terminal value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_level <= '0;
            btn_press <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                btn_press[i] <= 1'b0;
                if (sync2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    cnt[i]       <= '0;
                    btn_level[i] <= sync2[i];
                    btn_press[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre         <= '0;
            blink_phase <= 1'b0;
        end else if (pre == PRE_LAST) begin
            pre         <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) mode_q[i] <= OFF;
        end else begin
            for (int unsigned i = 0; i < 4; i++) mode_q[i] <= mode_d[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            mode_d[i] = mode_q[i];
            case (mode_q[i])
                OFF:     if (btn_press[i]) mode_d[i] = ON;
                ON:      if (btn_press[i]) mode_d[i] = BLINK;
                BLINK:   if (btn_press[i]) mode_d[i] = OFF;
                default: mode_d[i] = OFF;
            endcase
        end
    end

    always_comb begin
        leds_d   = '0;
        led_mode = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            led_mode[2*i +: 2] = mode_q[i];
            case (mode_q[i])
                ON:      leds_d[i] = 1'b1;
                BLINK:   leds_d[i] = blink_phase;
                default: leds_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) leds <= '0;
        else        leds <= leds_d;
    end

endmodule

// File: tb/tb_wingbutled_ctrl_v.sv
// Directed bench for wingbutled_ctrl_v with DEBOUNCE_CYCLES=4, BLINK_CYCLES=3.
module tb_wingbutled_ctrl_v;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] buttons;
    logic [3:0] leds, btn_level, btn_press;
    logic [7:0] led_mode;

    int checks = 0;
    int errors = 0;

    wingbutled_ctrl_v #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buttons   (buttons),
        .leds      (leds),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .led_mode  (led_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [7:0] mode;
        logic [3:0] led;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [7:0] mode, input logic [3:0] led);
        chk({tag, " btn_level"}, {4'h0, btn_level}, {4'h0, lvl});
        chk({tag, " btn_press"}, {4'h0, btn_press}, {4'h0, prs});
        chk({tag, " led_mode"}, led_mode, mode);
        chk({tag, " leds"}, {4'h0, leds}, {4'h0, led});
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        buttons = '0;
        step();
        rst_n = 1'b1;
    endtask

    // Press, observe the single pulse, release and let the release debounce out.
    task automatic press_release(input int unsigned ch);
        logic [3:0] b;
        b = 4'b0001 << ch;
        buttons = buttons | b;
        repeat (5) step();
        step();
        chk("press pulse", {4'h0, btn_press}, {4'h0, b});
        step();
        chk("press pulse end", {4'h0, btn_press}, 8'h00);
        buttons = buttons & ~b;
        repeat (7) step();
    endtask

    initial begin
        logic v0;
        logic found;
        rst_n   = 1'b0;
        buttons = '0;

        // Clean press on channel 0 from reset, then release (raw fall before edge 9)
        vecs[0]  = '{1'b0, 4'b0000, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[1]  = '{1'b1, 4'b0001, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[2]  = '{1'b1, 4'b0001, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[3]  = '{1'b1, 4'b0001, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[4]  = '{1'b1, 4'b0001, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[5]  = '{1'b1, 4'b0001, 4'h0, 4'h0, 8'h00, 4'h0};
        vecs[6]  = '{1'b1, 4'b0001, 4'h1, 4'h1, 8'h00, 4'h0};
        vecs[7]  = '{1'b1, 4'b0001, 4'h1, 4'h0, 8'h01, 4'h0};
        vecs[8]  = '{1'b1, 4'b0001, 4'h1, 4'h0, 8'h01, 4'h1};
        vecs[9]  = '{1'b1, 4'b0000, 4'h1, 4'h0, 8'h01, 4'h1};
        vecs[10] = '{1'b1, 4'b0000, 4'h1, 4'h0, 8'h01, 4'h1};
        vecs[11] = '{1'b1, 4'b0000, 4'h1, 4'h0, 8'h01, 4'h1};
        vecs[12] = '{1'b1, 4'b0000, 4'h1, 4'h0, 8'h01, 4'h1};
        vecs[13] = '{1'b1, 4'b0000, 4'h1, 4'h0, 8'h01, 4'h1};
        vecs[14] = '{1'b1, 4'b0000, 4'h0, 4'h0, 8'h01, 4'h1};
        vecs[15] = '{1'b1, 4'b0000, 4'h0, 4'h0, 8'h01, 4'h1};

        for (int i = 0; i < 16; i++) begin
            rst_n   = vecs[i].rst_n;
            buttons = vecs[i].btn;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].mode, vecs[i].led);
        end

        // Glitch of 3 cycles on channel 2 must be ignored
        do_reset();
        buttons = 4'b0100;
        repeat (3) step();
        buttons = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_all("glitch", 4'h0, 4'h0, 8'h00, 4'h0);
        end

        // Mode cycling on channel 1
        do_reset();
        press_release(1);
        chk("mode ch1 ON", {6'h0, led_mode[3:2]}, 8'h01);
        chk("leds ch1 ON", {4'h0, leds}, 8'h02);
        press_release(1);
        chk("mode ch1 BLINK", {6'h0, led_mode[3:2]}, 8'h02);
        found = 1'b0;
        v0    = leds[1];
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            if (leds[1] !== v0) found = 1'b1;
        end
        chk("blink toggle seen", {7'h0, found}, 8'h01);
        v0 = leds[1];
        for (int k = 1; k < 7; k++) begin
            step();
            chk("blink period", {7'h0, leds[1]}, {7'h0, v0 ^ ((k / 3) % 2 == 1)});
        end
        press_release(1);
        chk("mode ch1 OFF", led_mode, 8'h00);
        chk("leds ch1 OFF", {4'h0, leds}, 8'h00);

        // Simultaneous presses
        do_reset();
        buttons = 4'b1111;
        repeat (5) step();
        chk("simul pre", {4'h0, btn_press}, 8'h00);
        step();
        chk_all("simul press", 4'hF, 4'hF, 8'h00, 4'h0);
        step();
        chk_all("simul mode", 4'hF, 4'h0, 8'h55, 4'h0);
        step();
        chk_all("simul leds", 4'hF, 4'h0, 8'h55, 4'hF);

        // Reset two counts into the channel-3 debounce, button held throughout
        do_reset();
        buttons = 4'b1000;
        repeat (4) step();
        chk("mid-deb level", {4'h0, btn_level}, 8'h00);
        rst_n = 1'b0;
        step();
        chk_all("mid-deb reset", 4'h0, 4'h0, 8'h00, 4'h0);
        rst_n = 1'b1;
        repeat (5) step();
        chk_all("mid-deb r5", 4'h0, 4'h0, 8'h00, 4'h0);
        step();
        chk_all("mid-deb r6", 4'h8, 4'h8, 8'h00, 4'h0);
        step();
        chk_all("mid-deb mode", 4'h8, 4'h0, 8'h40, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
